// File: rtl/parity_pkg.sv
// Shared frame definitions for the serial parity encoder/decoder pair.
package parity_pkg;

    localparam int DATA_W  = 15;
    localparam int FRAME_W = DATA_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Returns 1 when the frame has an odd number of ones (even-parity failure).
    function automatic logic even_parity(input logic [FRAME_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/parity_decoder.sv
// Serial even-parity frame checker: reassembles DATA_W data bits plus a trailing
// parity bit, flags parity errors and keeps a saturating error count.
module parity_decoder
    import parity_pkg::*;
#(
    parameter int DATA_W = parity_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_din,
    input  logic              i_din_valid,
    input  logic              i_sof,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    output logic              o_parity_err,
    output logic              o_frame_abort,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int IDX_W = $clog2(DATA_W + 1);

    state_t             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_par;
    logic [DATA_W-1:0]  r_dout;
    logic               r_dout_valid;
    logic               r_parity_err;
    logic               r_frame_abort;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_start;
    logic               w_data_bit;
    logic               w_last;
    logic               w_frame_err;

    assign w_start     = i_din_valid && i_sof;
    assign w_data_bit  = i_din_valid && !i_sof && (r_state == RECV);
    assign w_last      = (r_idx == IDX_W'(DATA_W));
    assign w_frame_err = r_par ^ i_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_idx         <= '0;
            r_par         <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_dout_valid  <= 1'b0;
            r_frame_abort <= 1'b0;
            if (w_start) begin
                // sof always restarts; it is only an abort if a frame was in flight
                r_frame_abort <= (r_state == RECV);
                r_shift       <= {{(DATA_W-1){1'b0}}, i_din};
                r_par         <= i_din;
                r_idx         <= IDX_W'(1);
                r_state       <= RECV;
            end else if (w_data_bit) begin
                if (w_last) begin
                    r_dout       <= r_shift;
                    r_parity_err <= w_frame_err;
                    r_dout_valid <= 1'b1;
                    if (w_frame_err && (r_err_cnt != {CNT_W{1'b1}}))
                        r_err_cnt <= r_err_cnt + 1'b1;
                    r_state      <= IDLE;
                    r_idx        <= '0;
                    r_par        <= 1'b0;
                end else begin
                    r_shift <= {r_shift[DATA_W-2:0], i_din};
                    r_par   <= w_frame_err;
                    r_idx   <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_dout        = r_dout;
    assign o_dout_valid  = r_dout_valid;
    assign o_parity_err  = r_parity_err;
    assign o_frame_abort = r_frame_abort;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_parity_decoder.sv
// Directed bench for parity_decoder: hand-computed frames, gaps, aborts,
// counter saturation and mid-frame reset.
module tb_parity_decoder;
    import parity_pkg::*;

    localparam int DW = 15;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          i_din;
    logic          i_din_valid;
    logic          i_sof;
    logic [DW-1:0] o_dout;
    logic          o_dout_valid;
    logic          o_parity_err;
    logic          o_frame_abort;
    logic [CW-1:0] o_err_cnt;

    int n_tests;
    int n_fail;
    int cyc;
    int dv_cnt;
    int fa_cnt;
    logic bb_mode;
    int bb_n;
    int bb_first;
    int bb_last;

    parity_decoder #(.DATA_W(DW), .CNT_W(CW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .i_sof        (i_sof),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .o_parity_err (o_parity_err),
        .o_frame_abort(o_frame_abort),
        .o_err_cnt    (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and back-to-back spacing tracker, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (o_dout_valid)  dv_cnt <= dv_cnt + 1;
        if (o_frame_abort) fa_cnt <= fa_cnt + 1;
        if (!bb_mode) begin
            bb_n <= 0;
        end else if (o_dout_valid) begin
            if (bb_n == 0) bb_first <= cyc;
            bb_last <= cyc;
            bb_n    <= bb_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic s);
        @(negedge clk);
        i_din       = b;
        i_din_valid = 1'b1;
        i_sof       = s;
    endtask

    task automatic idle();
        @(negedge clk);
        i_din       = 1'b0;
        i_din_valid = 1'b0;
        i_sof       = 1'b0;
    endtask

    // Sends a full frame MSB first; gap_after >= 0 inserts 3 idle cycles after that bit index.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input int gap_after);
        for (int i = 0; i <= DW; i++) begin
            drive((i < DW) ? d[DW-1-i] : p, i == 0);
            if (i == gap_after) begin
                idle(); idle(); idle();
            end
        end
    endtask

    initial begin
        int dv0;
        int fa0;
        logic [DW-1:0] d;
        logic [DW-1:0] old_d;
        n_tests = 0; n_fail = 0; cyc = 0; dv_cnt = 0; fa_cnt = 0;
        bb_mode = 1'b0; bb_n = 0; bb_first = 0; bb_last = 0;
        i_din = 1'b0; i_din_valid = 1'b0; i_sof = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(o_dout), 32'h0);
        chk("rst_dv", 32'(o_dout_valid), 32'h0);
        chk("rst_perr", 32'(o_parity_err), 32'h0);
        chk("rst_fa", 32'(o_frame_abort), 32'h0);
        chk("rst_cnt", 32'(o_err_cnt), 32'h0);
        rst_n = 1'b1;

        // Good frame
        dv0 = dv_cnt;
        send_frame(15'h0001, 1'b1, -1);
        idle();
        chk("f1_dout", 32'(o_dout), 32'h0001);
        chk("f1_dv", 32'(o_dout_valid), 32'h1);
        chk("f1_perr", 32'(o_parity_err), 32'h0);
        chk("f1_cnt", 32'(o_err_cnt), 32'h0);
        idle();
        chk("f1_dv_pulse", 32'(o_dout_valid), 32'h0);
        chk("f1_dv_once", 32'(dv_cnt - dv0), 32'h1);

        // Bad parity, flag held afterwards
        send_frame(15'h0001, 1'b0, -1);
        idle();
        chk("f2_perr", 32'(o_parity_err), 32'h1);
        chk("f2_cnt", 32'(o_err_cnt), 32'h1);
        idle(); idle(); idle();
        chk("f2_perr_held", 32'(o_parity_err), 32'h1);
        chk("f2_dv_low", 32'(o_dout_valid), 32'h0);

        // Gap of 3 cycles after bit 5
        send_frame(15'h2AAA, 1'b1, 5);
        idle();
        chk("f3_dout", 32'(o_dout), 32'h2AAA);
        chk("f3_perr", 32'(o_parity_err), 32'h0);
        chk("f3_cnt", 32'(o_err_cnt), 32'h1);

        // Abort after 8 bits, restart with 15'h7FFF
        idle();
        dv0 = dv_cnt; fa0 = fa_cnt;
        d = 15'h1234;
        for (int i = 0; i < 8; i++) drive(d[DW-1-i], i == 0);
        drive(1'b1, 1'b1);
        @(posedge clk); #1;
        chk("ab_fa", 32'(o_frame_abort), 32'h1);
        for (int i = 1; i <= DW; i++) drive(1'b1, 1'b0);
        idle();
        chk("ab_dout", 32'(o_dout), 32'h7FFF);
        chk("ab_perr", 32'(o_parity_err), 32'h0);
        idle();
        chk("ab_dv_once", 32'(dv_cnt - dv0), 32'h1);
        chk("ab_fa_once", 32'(fa_cnt - fa0), 32'h1);

        // 300 back-to-back bad-parity frames
        dv0 = dv_cnt; fa0 = fa_cnt;
        bb_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            d = DW'(k * 37 + 5);
            send_frame(d, ~even_parity({d, 1'b0}), -1);
        end
        old_d = d;
        idle();
        chk("bb_cnt_sat", 32'(o_err_cnt), 32'hFF);
        chk("bb_perr", 32'(o_parity_err), 32'h1);
        chk("bb_dout", 32'(o_dout), 32'(old_d));
        idle();
        chk("bb_dv_cnt", 32'(dv_cnt - dv0), 32'd300);
        chk("bb_no_abort", 32'(fa_cnt - fa0), 32'h0);
        chk("bb_n", 32'(bb_n), 32'd300);
        chk("bb_spacing", 32'(bb_last - bb_first), 32'd16 * 32'd299);
        bb_mode = 1'b0;

        // Reset after bit 10 of a frame
        fa0 = fa_cnt;
        d = 15'h5555;
        for (int i = 0; i <= 10; i++) drive(d[DW-1-i], i == 0);
        @(negedge clk);
        i_din_valid = 1'b0; i_sof = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_dout", 32'(o_dout), 32'h0);
        chk("mr_perr", 32'(o_parity_err), 32'h0);
        chk("mr_cnt", 32'(o_err_cnt), 32'h0);
        chk("mr_dv", 32'(o_dout_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dv0 = dv_cnt;
        for (int i = 0; i < 20; i++) drive(i[0], 1'b0);
        idle(); idle();
        chk("mr_ignored_dv", 32'(dv_cnt - dv0), 32'h0);
        chk("mr_no_abort", 32'(fa_cnt - fa0), 32'h0);
        send_frame(15'h1234, 1'b1, -1);
        idle();
        chk("mr_dout2", 32'(o_dout), 32'h1234);
        chk("mr_perr2", 32'(o_parity_err), 32'h0);
        chk("mr_dv2", 32'(o_dout_valid), 32'h1);
        send_frame(15'h4000, 1'b0, -1);
        idle();
        chk("mr_dout3", 32'(o_dout), 32'h4000);
        chk("mr_perr3", 32'(o_parity_err), 32'h1);
        chk("mr_cnt3", 32'(o_err_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
